// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Brief    : Single-command bus initiator for the ArgonALU. Writes operands,
//             opcode and optional flags preload, then reads Y and flags back.
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int WORDSIZE = 16,
    parameter int OPW      = 4
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_cmdValid,
    output logic                o_cmdReady,
    input  logic [WORDSIZE-1:0] i_cmdA,
    input  logic [WORDSIZE-1:0] i_cmdB,
    input  logic [OPW-1:0]      i_cmdOp,
    input  logic                i_cmdWrF,
    input  logic [WORDSIZE-1:0] i_cmdFlags,
    output logic                o_rspValid,
    input  logic                i_rspReady,
    output logic [WORDSIZE-1:0] o_rspY,
    output logic [WORDSIZE-1:0] o_rspFlags,
    output logic                o_rspErr,
    output logic [WORDSIZE-1:0] o_busData,
    output logic                o_busValid,
    input  logic [WORDSIZE-1:0] i_busData,
    input  logic                i_busValid,
    output logic                o_latchA,
    output logic                o_latchB,
    output logic                o_latchF,
    output logic                o_latchOp,
    output logic                o_outputY,
    output logic                o_outputF
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WR_F  = 3'd1;
    localparam logic [2:0] c_WR_A  = 3'd2;
    localparam logic [2:0] c_WR_B  = 3'd3;
    localparam logic [2:0] c_WR_OP = 3'd4;
    localparam logic [2:0] c_EXEC  = 3'd5;
    localparam logic [2:0] c_RD_F  = 3'd6;
    localparam logic [2:0] c_RESP  = 3'd7;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic                w_accept;
    logic [WORDSIZE-1:0] r_cmd_a;
    logic [WORDSIZE-1:0] r_cmd_b;
    logic [WORDSIZE-1:0] r_cmd_flags;
    logic [OPW-1:0]      r_cmd_op;
    logic [WORDSIZE-1:0] r_rsp_y;
    logic [WORDSIZE-1:0] r_rsp_flags;
    logic                r_rsp_err;

    assign w_accept = i_cmdValid && (r_state == c_IDLE);

    // Writes run back-to-back: any bus-valid gap lets the ALU recompute flags.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (i_cmdValid) w_next_state = i_cmdWrF ? c_WR_F : c_WR_A;
            c_WR_F:  w_next_state = c_WR_A;
            c_WR_A:  w_next_state = c_WR_B;
            c_WR_B:  w_next_state = c_WR_OP;
            c_WR_OP: w_next_state = c_EXEC;
            c_EXEC:  w_next_state = c_RD_F;
            c_RD_F:  w_next_state = c_RESP;
            c_RESP:  if (i_rspReady) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= c_IDLE;
            r_cmd_a     <= '0;
            r_cmd_b     <= '0;
            r_cmd_flags <= '0;
            r_cmd_op    <= '0;
            r_rsp_y     <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cmd_a     <= i_cmdA;
                r_cmd_b     <= i_cmdB;
                r_cmd_flags <= i_cmdFlags;
                r_cmd_op    <= i_cmdOp;
                r_rsp_err   <= 1'b0;
            end
            // Y must be taken in EXEC; flags move once bus valid is low.
            if (r_state == c_EXEC) begin
                r_rsp_y <= i_busData;
                if (!i_busValid) r_rsp_err <= 1'b1;
            end
            if (r_state == c_RD_F) begin
                r_rsp_flags <= i_busData;
                if (!i_busValid) r_rsp_err <= 1'b1;
            end
        end
    end

    always_comb begin
        o_busData = '0;
        case (r_state)
            c_WR_F:  o_busData = r_cmd_flags;
            c_WR_A:  o_busData = r_cmd_a;
            c_WR_B:  o_busData = r_cmd_b;
            c_WR_OP: o_busData = {{(WORDSIZE-OPW){1'b0}}, r_cmd_op};
            default: o_busData = '0;
        endcase
    end

    assign o_cmdReady = (r_state == c_IDLE);
    assign o_rspValid = (r_state == c_RESP);
    assign o_busValid = (r_state == c_WR_F) || (r_state == c_WR_A) ||
                        (r_state == c_WR_B) || (r_state == c_WR_OP);
    assign o_latchF   = (r_state == c_WR_F);
    assign o_latchA   = (r_state == c_WR_A);
    assign o_latchB   = (r_state == c_WR_B);
    assign o_latchOp  = (r_state == c_WR_OP);
    assign o_outputY  = (r_state == c_EXEC);
    assign o_outputF  = (r_state == c_RD_F);
    assign o_rspY     = r_rsp_y;
    assign o_rspFlags = r_rsp_flags;
    assign o_rspErr   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Brief    : Self-checking bench for alu_sequencer with a behavioural ALU.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_LSH = 4'd7;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_cmdValid = 1'b0;
    logic        o_cmdReady;
    logic [15:0] i_cmdA = '0;
    logic [15:0] i_cmdB = '0;
    logic [3:0]  i_cmdOp = '0;
    logic        i_cmdWrF = 1'b0;
    logic [15:0] i_cmdFlags = '0;
    logic        o_rspValid;
    logic        i_rspReady = 1'b0;
    logic [15:0] o_rspY;
    logic [15:0] o_rspFlags;
    logic        o_rspErr;
    logic [15:0] o_busData;
    logic        o_busValid;
    logic [15:0] i_busData;
    logic        i_busValid;
    logic        o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF;

    alu_sequencer #(.WORDSIZE(16), .OPW(4)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady),
        .i_cmdA(i_cmdA), .i_cmdB(i_cmdB), .i_cmdOp(i_cmdOp),
        .i_cmdWrF(i_cmdWrF), .i_cmdFlags(i_cmdFlags),
        .o_rspValid(o_rspValid), .i_rspReady(i_rspReady),
        .o_rspY(o_rspY), .o_rspFlags(o_rspFlags), .o_rspErr(o_rspErr),
        .o_busData(o_busData), .o_busValid(o_busValid),
        .i_busData(i_busData), .i_busValid(i_busValid),
        .o_latchA(o_latchA), .o_latchB(o_latchB), .o_latchF(o_latchF),
        .o_latchOp(o_latchOp), .o_outputY(o_outputY), .o_outputF(o_outputF)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic        bv;
        logic [15:0] bd;
        logic [5:0]  stb;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [15:0] rsp_log[$];
    logic        exp_pending = 1'b0;
    logic [15:0] exp_y = '0;
    logic [15:0] exp_f = '0;
    logic        exp_err = 1'b0;
    logic        drop_exec = 1'b0;
    logic [16:0] mdl_r;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;

    logic [5:0] stb;
    assign stb = {o_latchF, o_latchA, o_latchB, o_latchOp, o_outputY, o_outputF};

    // Carry is bit 16 (borrow for subtracts); flags word = {zero, carry}.
    function automatic logic [16:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] op, input logic cin);
        logic [16:0] r;
        case (op)
            4'd0:       r = {1'b0, a} + {1'b0, b};
            4'd1:       r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            4'd2, 4'd9: r = {1'b0, a} - {1'b0, b};
            4'd3:       r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
            4'd4:       r = {1'b0, a & b};
            4'd5:       r = {1'b0, a | b};
            4'd6:       r = {1'b0, a ^ b};
            4'd7:       r = {1'b0, a} << b[3:0];
            4'd8:       r = {1'b0, a >> b[3:0]};
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] flags_of(input logic [16:0] r);
        return {14'd0, (r[15:0] == 16'd0), r[16]};
    endfunction

    function automatic cyc_t mk(input logic bv, input logic [15:0] bd, input logic [5:0] s);
        cyc_t c;
        c.bv = bv; c.bd = bd; c.stb = s;
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Behavioural ALU: latches on bus-valid strobes, recomputes flags otherwise.
    logic [15:0] alu_a = '0, alu_b = '0, alu_f = '0;
    logic [3:0]  alu_op = '0;
    logic [16:0] alu_r;
    assign alu_r = alu_calc(alu_a, alu_b, alu_op, alu_f[0]);

    always @(posedge i_Clk) begin
        if (o_busValid) begin
            if (o_latchA)  alu_a  <= o_busData;
            if (o_latchB)  alu_b  <= o_busData;
            if (o_latchF)  alu_f  <= o_busData;
            if (o_latchOp) alu_op <= o_busData[3:0];
        end else begin
            alu_f <= flags_of(alu_r);
        end
    end

    always_comb begin
        i_busData  = '0;
        i_busValid = 1'b0;
        if (o_outputY) begin
            i_busData  = alu_r[15:0];
            i_busValid = !drop_exec;
        end else if (o_outputF) begin
            i_busData  = alu_f;
            i_busValid = 1'b1;
        end
    end

    // Transaction model: on accept, queue the expected per-cycle bus activity.
    initial forever begin
        @(posedge i_Clk);
        cyc++;
        if (i_Reset) begin
            exp_q.delete();
            exp_pending = 1'b0;
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (exp_pending) begin
            if (i_rspReady) exp_pending = 1'b0;
        end else if (i_cmdValid) begin
            if (i_cmdWrF) exp_q.push_back(mk(1'b1, i_cmdFlags, 6'b100000));
            exp_q.push_back(mk(1'b1, i_cmdA, 6'b010000));
            exp_q.push_back(mk(1'b1, i_cmdB, 6'b001000));
            exp_q.push_back(mk(1'b1, {12'd0, i_cmdOp}, 6'b000100));
            exp_q.push_back(mk(1'b0, 16'd0, 6'b000010));
            exp_q.push_back(mk(1'b0, 16'd0, 6'b000001));
            mdl_r       = alu_calc(i_cmdA, i_cmdB, i_cmdOp, i_cmdWrF ? i_cmdFlags[0] : 1'b0);
            exp_y       = mdl_r[15:0];
            exp_f       = flags_of(mdl_r);
            exp_err     = drop_exec;
            exp_pending = 1'b1;
            acc_cnt++;
            acc_cyc     = cyc;
        end
    end

    initial forever begin
        @(posedge i_Clk);
        if (!i_Reset && o_rspValid && i_rspReady) rsp_log.push_back(o_rspY);
    end

    initial forever begin
        @(negedge i_Clk);
        if (!i_Reset) begin
            if (exp_q.size() > 0)
                check("seq_cycle", 64'({o_cmdReady, o_rspValid, o_busValid, o_busData, stb}),
                      64'({2'b00, exp_q[0]}));
            else if (exp_pending)
                check("resp_cycle",
                      64'({o_cmdReady, o_rspValid, o_busValid, o_busData, stb, o_rspY, o_rspFlags, o_rspErr}),
                      64'({1'b0, 1'b1, 1'b0, 16'd0, 6'd0, exp_y, exp_f, exp_err}));
            else
                check("idle_cycle", 64'({o_cmdReady, o_rspValid, o_busValid, o_busData, stb}),
                      64'({1'b1, 1'b0, 1'b0, 16'd0, 6'd0}));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input logic wrf, input logic [15:0] fl);
        int n;
        int start;
        i_cmdA = a; i_cmdB = b; i_cmdOp = op; i_cmdWrF = wrf; i_cmdFlags = fl;
        i_cmdValid = 1'b1;
        start = acc_cnt;
        n = 0;
        while (acc_cnt == start && n < 40) begin
            @(posedge i_Clk); #2; n++;
        end
        if (acc_cnt == start) fail_now("accept_timeout");
        // Scramble inputs to show the command copy is held internally.
        i_cmdValid = 1'b0;
        i_cmdA = 16'($urandom); i_cmdB = 16'($urandom); i_cmdOp = 4'($urandom);
        i_cmdFlags = 16'($urandom); i_cmdWrF = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_rsp(input int hold, input bit poke, output int lat,
                            output logic [15:0] y, output logic [15:0] f, output logic e);
        lat = 0;
        do begin
            @(negedge i_Clk); lat++;
        end while (!o_rspValid && lat < 30);
        if (!o_rspValid) fail_now("rsp_timeout");
        y = o_rspY; f = o_rspFlags; e = o_rspErr;
        for (int i = 0; i < hold; i++) begin
            #1;
            if (poke) begin
                i_cmdValid = 1'b1; i_cmdA = 16'($urandom); i_cmdOp = 4'($urandom);
            end
            @(negedge i_Clk);
            check("rsp_hold", 64'({o_rspValid, o_cmdReady, o_rspY, o_rspFlags}),
                  64'({1'b1, 1'b0, y, f}));
        end
        #1;
        i_cmdValid = 1'b0;
        i_rspReady = 1'b1;
        @(posedge i_Clk); #2;
        i_rspReady = 1'b0;
    endtask

    initial begin
        int          lat, n, first_cyc, acc0;
        logic [15:0] y, f;
        logic        e;
        logic        wrf;
        logic [3:0]  op;

        repeat (3) @(negedge i_Clk);
        check("reset_state", 64'({o_cmdReady, o_rspValid, o_busValid, o_busData, stb, o_rspY, o_rspFlags, o_rspErr}),
              64'({1'b1, 1'b0, 1'b0, 16'd0, 6'd0, 16'd0, 16'd0, 1'b0}));
        #1 i_Reset = 1'b0;

        send(16'h1234, 16'h0F0F, OP_ADD, 1'b0, 16'h0000);
        wait_rsp(0, 1'b0, lat, y, f, e);
        check("add_latency", 64'(lat), 64'd6);
        check("add_y", 64'(y), 64'h2143);
        check("add_flags", 64'(f), 64'h0000);

        send(16'hFFFF, 16'h0000, OP_ADC, 1'b1, 16'h0001);
        wait_rsp(0, 1'b0, lat, y, f, e);
        check("adc_latency", 64'(lat), 64'd7);
        check("adc_y", 64'(y), 64'h0000);
        check("adc_flags", 64'(f), 64'h0003);

        send(16'h0100, 16'h0200, OP_ADD, 1'b0, 16'h0000);
        acc0 = acc_cnt;
        wait_rsp(5, 1'b1, lat, y, f, e);
        check("bp_y", 64'(y), 64'h0300);
        @(negedge i_Clk);
        check("bp_back_to_idle", 64'({o_cmdReady, o_rspValid}), 64'({1'b1, 1'b0}));
        check("bp_no_extra_accept", 64'(acc_cnt), 64'(acc0));

        send(16'h4444, 16'h2222, OP_ADD, 1'b0, 16'h0000);
        @(negedge i_Clk);
        @(negedge i_Clk);
        check("midop_in_wrb", 64'(o_latchB), 64'd1);
        #1 i_Reset = 1'b1;
        #1 check("async_reset_drop", 64'({o_cmdReady, o_rspValid, o_busValid, o_busData, stb}),
                 64'({1'b1, 1'b0, 1'b0, 16'd0, 6'd0}));
        @(negedge i_Clk);
        @(negedge i_Clk);
        #1 i_Reset = 1'b0;
        send(16'd5, 16'd3, OP_SBC, 1'b1, 16'h0000);
        wait_rsp(1, 1'b0, lat, y, f, e);
        check("sbc_after_reset_y", 64'(y), 64'h0002);
        check("sbc_latency", 64'(lat), 64'd7);

        drop_exec = 1'b1;
        send(16'h00FF, 16'h0F0F, OP_XOR, 1'b0, 16'h0000);
        wait_rsp(0, 1'b0, lat, y, f, e);
        check("err_set", 64'(e), 64'd1);
        drop_exec = 1'b0;
        send(16'h0001, 16'h0001, OP_ADD, 1'b0, 16'h0000);
        wait_rsp(0, 1'b0, lat, y, f, e);
        check("err_cleared", 64'(e), 64'd0);

        // Valid held high across two commands; one accept per IDLE visit.
        rsp_log.delete();
        acc0 = acc_cnt;
        i_rspReady = 1'b1;
        i_cmdA = 16'hAAAA; i_cmdB = 16'h5555; i_cmdOp = OP_XOR; i_cmdWrF = 1'b0;
        i_cmdValid = 1'b1;
        n = 0;
        while (acc_cnt == acc0 && n < 40) begin @(posedge i_Clk); #2; n++; end
        first_cyc = acc_cyc;
        i_cmdA = 16'h0001; i_cmdB = 16'h0004; i_cmdOp = OP_LSH;
        n = 0;
        while (acc_cnt == acc0 + 1 && n < 40) begin @(posedge i_Clk); #2; n++; end
        i_cmdValid = 1'b0;
        check("b2b_spacing", 64'(acc_cyc - first_cyc), 64'd7);
        n = 0;
        while ((exp_pending || exp_q.size() > 0) && n < 40) begin @(posedge i_Clk); #2; n++; end
        if (exp_pending) fail_now("b2b_drain");
        i_rspReady = 1'b0;
        check("b2b_accepts", 64'(acc_cnt - acc0), 64'd2);
        check("b2b_rsp_count", 64'(rsp_log.size()), 64'd2);
        if (rsp_log.size() == 2) begin
            check("b2b_xor_y", 64'(rsp_log[0]), 64'hFFFF);
            check("b2b_lsh_y", 64'(rsp_log[1]), 64'h0010);
        end

        for (int k = 0; k < 30; k++) begin
            op  = 4'($urandom_range(0, 15));
            wrf = (op == OP_ADC || op == OP_SBC) ? 1'b1 : 1'($urandom_range(0, 1));
            send(16'($urandom), 16'($urandom), op, wrf, 16'($urandom));
            wait_rsp(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat, y, f, e);
            check("rand_latency", 64'(lat), wrf ? 64'd7 : 64'd6);
        end

        repeat (3) @(negedge i_Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
